// File: rtl/conv_window_sched_pkg.sv
// conv_pkg: shared definitions for the 3x3 stencil window scheduler.
//   state_t    - scheduler FSM states
//   TAP_CNT    - taps per window (3x3)
//   TAP_W      - width of the tap index
//   PIX_W      - pixel / data width
//   is_border  - border-pixel test on a (row, col) pair
package conv_pkg;

  localparam int TAP_CNT = 9;
  localparam int TAP_W   = 4;
  localparam int PIX_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BRD_RD   = 3'd1,
    S_BRD_WR   = 3'd2,
    S_FETCH    = 3'd3,
    S_DRAIN    = 3'd4,
    S_WAIT_RES = 3'd5,
    S_WRITE    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  // A pixel is border when it touches any image edge.
  function automatic logic is_border(input logic [31:0] row,
                                     input logic [31:0] col,
                                     input logic [31:0] last_row,
                                     input logic [31:0] last_col);
    return (row == 32'd0) || (row == last_row) ||
           (col == 32'd0) || (col == last_col);
  endfunction

endpackage

// File: rtl/conv_window_sched_if.sv
// conv_window_sched_if: bundle of the scheduler's control, source-read,
// tap-stream, datapath-result and destination-write signals.
//
// Handshake semantics (all single-cycle, sampled on rising clk):
//   start     : host request, only honoured while busy=0.
//   busy/done : busy high for every non-idle cycle; done pulses once at frame end.
//   rd_en     : rd_data carries mem[rd_addr] in the following cycle.
//   tap_valid : rd_data is window tap tap_idx this cycle.
//   acc_clr   : first tap of a new window; datapath drops pix_valid until
//               the new result is ready, then holds it until the next acc_clr.
//   wr_en     : wr_data is written to wr_addr at the rising edge.
//
// Modports: master = scheduler side, slave = environment (memories/datapath/host).
interface conv_window_sched_if
  import conv_pkg::*;
#(
  parameter int ADDR_W = 14
) ();

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              tap_valid;
  logic [TAP_W-1:0]  tap_idx;
  logic              acc_clr;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    input  start, rd_data, pix_valid, pix_result,
    output busy, done, rd_en, rd_addr, tap_valid, tap_idx, acc_clr,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, pix_valid, pix_result,
    input  busy, done, rd_en, rd_addr, tap_valid, tap_idx, acc_clr,
           wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/conv_window_sched_addr_gen.sv
// conv_addr_gen: raster position counters and address arithmetic.
//   clk, rst          : clock, synchronous active-high reset
//   i_clear           : zero row/col/row_base (frame start)
//   i_advance         : step to the next pixel in raster order
//   i_tap             : window tap index 0..8 (row-major)
//   o_src_pix_addr    : SRC_BASE + row*IMG_W + col
//   o_dst_pix_addr    : DST_BASE + row*IMG_W + col
//   o_tap_addr        : source address of tap i_tap around (row, col)
//   o_last            : current pixel is the final one of the frame
//   o_next_border     : the pixel after an advance is a border pixel
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W    = 50,
  parameter int IMG_H    = 50,
  parameter int ADDR_W   = 14,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [TAP_W-1:0]  i_tap,
  output logic [ADDR_W-1:0] o_src_pix_addr,
  output logic [ADDR_W-1:0] o_dst_pix_addr,
  output logic [ADDR_W-1:0] o_tap_addr,
  output logic              o_last,
  output logic              o_next_border
);

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_row_base;   // row * IMG_W, kept incrementally

  logic              w_wrap;
  logic [ADDR_W-1:0] w_next_row;
  logic [ADDR_W-1:0] w_next_col;
  logic [ADDR_W-1:0] w_center;
  logic [ADDR_W-1:0] w_row_part;
  logic [ADDR_W-1:0] w_tap_off;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (i_advance) begin
      if (w_wrap) begin
        r_col      <= '0;
        r_row      <= r_row + ONE_A;
        r_row_base <= r_row_base + W_A;
      end else begin
        r_col <= r_col + ONE_A;
      end
    end
  end

  assign w_wrap     = (r_col == LAST_COL);
  assign w_next_row = w_wrap ? r_row + ONE_A : r_row;
  assign w_next_col = w_wrap ? '0 : r_col + ONE_A;
  assign w_center   = r_row_base + r_col;

  // Tap (dr, dc) = (t/3-1, t%3-1). Interior pixels never underflow, so the
  // modular ADDR_W arithmetic is exact there.
  always_comb begin
    w_row_part = w_center;
    w_tap_off  = '0;
    case (i_tap)
      4'd0, 4'd1, 4'd2: w_row_part = w_center - W_A;
      4'd6, 4'd7, 4'd8: w_row_part = w_center + W_A;
      default:          w_row_part = w_center;
    endcase
    case (i_tap)
      4'd0, 4'd3, 4'd6: w_tap_off = '1;        // -1 in two's complement
      4'd2, 4'd5, 4'd8: w_tap_off = ONE_A;
      default:          w_tap_off = '0;
    endcase
  end

  assign o_tap_addr     = SRC_A + w_row_part + w_tap_off;
  assign o_src_pix_addr = SRC_A + w_center;
  assign o_dst_pix_addr = DST_A + w_center;
  assign o_last         = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign o_next_border  = is_border(32'(w_next_row), 32'(w_next_col),
                                    32'(LAST_ROW), 32'(LAST_COL));

endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: sequences a 3x3 stencil datapath over an IMG_W x IMG_H
// image. Border pixels are copied source->destination; interior pixels get
// nine tap reads streamed to the datapath, then its result is written out.
//   clk, rst     : clock, synchronous active-high reset
//   io_bus       : control/read/tap/result/write bundle (master side)
//   o_dbg_state  : current FSM state for observation
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int IMG_W    = 50,
  parameter int IMG_H    = 50,
  parameter int ADDR_W   = 14,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_window_sched_if.master  io_bus,
  output state_t               o_dbg_state
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAP_CNT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [TAP_W-1:0]  r_tap;
  logic [TAP_W-1:0]  w_next_tap;
  logic [PIX_W-1:0]  r_result;
  logic              r_tap_valid;
  logic [TAP_W-1:0]  r_tap_idx;

  logic              w_clear;
  logic              w_advance;
  logic              w_latch;
  logic [ADDR_W-1:0] w_src_pix_addr;
  logic [ADDR_W-1:0] w_dst_pix_addr;
  logic [ADDR_W-1:0] w_tap_addr;
  logic              w_last;
  logic              w_next_border;

  conv_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_clear),
    .i_advance     (w_advance),
    .i_tap         (r_tap),
    .o_src_pix_addr(w_src_pix_addr),
    .o_dst_pix_addr(w_dst_pix_addr),
    .o_tap_addr    (w_tap_addr),
    .o_last        (w_last),
    .o_next_border (w_next_border)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_result    <= '0;
      r_tap_valid <= 1'b0;
      r_tap_idx   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_tap       <= w_next_tap;
      // Read data arrives one cycle after rd_en, so the tap tag trails by one.
      r_tap_valid <= (r_state == S_FETCH);
      r_tap_idx   <= (r_state == S_FETCH) ? r_tap : '0;
      if (w_latch) r_result <= io_bus.pix_result;
    end
  end

  // Next-state logic. Pixel (0,0) is always border, so a frame opens in BRD_RD.
  always_comb begin
    w_next_state = r_state;
    w_next_tap   = r_tap;
    w_clear      = 1'b0;
    w_advance    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_clear      = 1'b1;
          w_next_state = S_BRD_RD;
        end
      end
      S_BRD_RD:  w_next_state = S_BRD_WR;
      S_FETCH: begin
        if (r_tap == LAST_TAP) begin
          w_next_tap   = '0;
          w_next_state = S_DRAIN;
        end else begin
          w_next_tap = r_tap + 1'b1;
        end
      end
      S_DRAIN:   w_next_state = S_WAIT_RES;
      S_WAIT_RES: begin
        if (io_bus.pix_valid) begin
          w_latch      = 1'b1;
          w_next_state = S_WRITE;
        end
      end
      S_BRD_WR, S_WRITE: begin
        w_next_tap = '0;
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_advance    = 1'b1;
          w_next_state = w_next_border ? S_BRD_RD : S_FETCH;
        end
      end
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output decode: read and write states are disjoint, so buses idle at zero.
  always_comb begin
    io_bus.busy      = (r_state != S_IDLE);
    io_bus.done      = (r_state == S_DONE);
    io_bus.rd_en     = 1'b0;
    io_bus.rd_addr   = '0;
    io_bus.acc_clr   = 1'b0;
    io_bus.wr_en     = 1'b0;
    io_bus.wr_addr   = '0;
    io_bus.wr_data   = '0;
    io_bus.tap_valid = r_tap_valid;
    io_bus.tap_idx   = r_tap_idx;
    case (r_state)
      S_BRD_RD: begin
        io_bus.rd_en   = 1'b1;
        io_bus.rd_addr = w_src_pix_addr;
      end
      S_FETCH: begin
        io_bus.rd_en   = 1'b1;
        io_bus.rd_addr = w_tap_addr;
        io_bus.acc_clr = (r_tap == '0);
      end
      S_BRD_WR: begin
        io_bus.wr_en   = 1'b1;
        io_bus.wr_addr = w_dst_pix_addr;
        io_bus.wr_data = io_bus.rd_data;
      end
      S_WRITE: begin
        io_bus.wr_en   = 1'b1;
        io_bus.wr_addr = w_dst_pix_addr;
        io_bus.wr_data = r_result;
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched on a 4x4 image (12 border, 4 interior pixels).
module tb_conv_window_sched;
  import conv_pkg::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int AW    = 14;
  localparam int SRC   = 0;
  localparam int DST   = 100;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int EW    = AW + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_sched_if #(.ADDR_W(AW)) bus ();
  state_t dbg_state;

  conv_window_sched #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(AW),
    .SRC_BASE(SRC), .DST_BASE(DST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_bus     (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- models / scoreboard state ----------------
  logic [7:0]    src_mem [NPIX];
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] acc_log[$];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  busy_cnt, done_cnt, wr_cnt, tap_cnt, tap_exp;
  int  fetch_left = 0;
  int  pv_cnt = 0;
  int  pv_rise_cyc = 0;
  int  rd3_cyc = 0;
  int  center;
  bit  done_seen;
  bit  prev_fetch = 0;
  bit  fetch_now;
  bit  pv_mode = 0;     // 0: pix_valid tied high, 1: datapath latency model

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] interior_res(input int c, input bit stall);
    if (stall && c == 6) return 8'h3C;
    return ~src_mem[c];
  endfunction

  // Source memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr];
  end

  // Monitor + datapath model, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      fetch_left = 0;
      prev_fetch = 0;
      tap_exp    = 0;
    end else begin
      if (bus.busy) begin
        busy_cnt++;
        check_eq("rd_wr_excl", 32'(bus.rd_en & bus.wr_en), 0);
      end
      if (bus.done) begin
        done_cnt++;
        done_seen = 1;
      end
      check_eq("tap_valid_align", 32'(bus.tap_valid), 32'(prev_fetch));

      fetch_now = 0;
      if (bus.acc_clr) begin
        check_eq("acc_clr_with_rd", 32'(bus.rd_en), 1);
        acc_log.push_back(bus.rd_addr);
        fetch_left = 9;
        center = int'(bus.rd_addr) + IMG_W + 1;
        bus.pix_result = interior_res(center, pv_mode);
        if (pv_mode) begin
          bus.pix_valid = 1'b0;
          pv_cnt = (center == 6) ? 15 : 10;
        end
      end else if (pv_mode && !bus.pix_valid && pv_cnt > 0) begin
        pv_cnt--;
        if (pv_cnt == 0) begin
          bus.pix_valid = 1'b1;
          pv_rise_cyc = cyc;
        end
      end
      if (!pv_mode) bus.pix_valid = 1'b1;

      if (bus.rd_en) begin
        rd_log.push_back(bus.rd_addr);
        if (bus.rd_addr == AW'(3)) rd3_cyc = cyc;
        if (fetch_left > 0) begin
          fetch_left--;
          fetch_now = 1;
        end
      end
      prev_fetch = fetch_now;

      if (bus.tap_valid) begin
        check_eq("tap_idx", 32'(bus.tap_idx), 32'(tap_exp));
        tap_exp = (tap_exp == 8) ? 0 : tap_exp + 1;
        tap_cnt++;
      end

      if (bus.wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("wr_unexpected", 32'(bus.wr_en), 0);
        end else begin
          check_eq("wr_addr_data", 32'({bus.wr_addr, bus.wr_data}), 32'(exp_q.pop_front()));
        end
        if (bus.wr_addr == AW'(DST + 3))
          check_eq("border_latency", 32'(cyc - rd3_cyc), 1);
        if (pv_mode && bus.wr_addr == AW'(DST + 6))
          check_eq("stall_wr_cycle", 32'(cyc), 32'(pv_rise_cyc + 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_expected(input bit stall);
    exp_q.delete();
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        int idx;
        logic [7:0] v;
        idx = r * IMG_W + c;
        if (r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1) v = src_mem[idx];
        else v = interior_res(idx, stall);
        exp_q.push_back({AW'(DST + idx), v});
      end
    end
  endtask

  task automatic clear_stats();
    rd_log.delete();
    acc_log.delete();
    busy_cnt  = 0;
    done_cnt  = 0;
    wr_cnt    = 0;
    tap_cnt   = 0;
    tap_exp   = 0;
    done_seen = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},      32'(bus.busy), 0);
    check_eq({tag, "_done"},      32'(bus.done), 0);
    check_eq({tag, "_rd_en"},     32'(bus.rd_en), 0);
    check_eq({tag, "_tap_valid"}, 32'(bus.tap_valid), 0);
    check_eq({tag, "_acc_clr"},   32'(bus.acc_clr), 0);
    check_eq({tag, "_wr_en"},     32'(bus.wr_en), 0);
    check_eq({tag, "_rd_addr"},   32'(bus.rd_addr), 0);
    check_eq({tag, "_wr_addr"},   32'(bus.wr_addr), 0);
    check_eq({tag, "_tap_idx"},   32'(bus.tap_idx), 0);
    check_eq({tag, "_wr_data"},   32'(bus.wr_data), 0);
    check_eq({tag, "_state"},     32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic run_frame(input bit stall, input bit poke);
    int exp_rd[9];
    int exp_acc[4];
    exp_rd  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    exp_acc = '{0, 1, 4, 5};
    pv_mode = stall;
    fill_expected(stall);
    clear_stats();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check_eq("first_rd_en",   32'(bus.rd_en), 1);
    check_eq("first_rd_addr", 32'(bus.rd_addr), SRC);
    for (int k = 0; k < 1000 && !done_seen; k++) begin
      @(negedge clk);
      bus.start = (poke && k == 20) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    check_eq("done_seen", 32'(done_seen), 1);
    repeat (2) @(negedge clk);
    check_eq("busy_cycles", 32'(busy_cnt), stall ? 78 : 73);
    check_eq("done_pulses", 32'(done_cnt), 1);
    check_eq("write_count", 32'(wr_cnt), 16);
    check_eq("exp_q_empty", 32'(exp_q.size()), 0);
    check_eq("tap_count",   32'(tap_cnt), 36);
    check_eq("read_count",  32'(rd_log.size()), 48);
    check_eq("acc_clr_count", 32'(acc_log.size()), 4);
    if (acc_log.size() == 4)
      for (int i = 0; i < 4; i++) check_eq("acc_clr_addr", 32'(acc_log[i]), 32'(exp_acc[i]));
    if (rd_log.size() >= 14)
      for (int i = 0; i < 9; i++) check_eq("p11_rd_addr", 32'(rd_log[5 + i]), 32'(exp_rd[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NPIX; i++) src_mem[i] = 8'(8'h20 + i * 7);
    src_mem[3] = 8'hA5;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    run_frame(1'b0, 1'b0);     // pix_valid tied high
    run_frame(1'b1, 1'b1);     // stall on pixel (1,2) + start while busy

    // Abort a frame with reset in the middle of an interior fetch.
    pv_mode = 1'b0;
    fill_expected(1'b0);
    clear_stats();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int k = 0; k < 200 && acc_log.size() == 0; k++) @(negedge clk);
    check_eq("abort_reached_fetch", 32'(acc_log.size() > 0), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    exp_q.delete();
    repeat (5) begin
      @(negedge clk);
      check_eq("no_wr_after_rst", 32'(bus.wr_en), 0);
      check_eq("idle_after_rst",  32'(bus.busy), 0);
    end

    run_frame(1'b0, 1'b0);     // full frame again from pixel (0,0)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
Controller that sequences the 3x3 stencil (Gaussian) datapath over an IMG_W x IMG_H 8-bit image held in a single-read-port source memory.
- Interior pixels: walks the image in raster order, issuing the nine window reads per interior pixel and streaming taps (with tap index) to the datapath.
- Result write: collects the datapath result and writes it to the destination memory.
- Border pixels: copied through unchanged.
- Handshake: start/busy/done with the top level.

Parameters:
IMG_W, 50, image width in pixels (>=3)
IMG_H, 50, image height in pixels (>=3)
ADDR_W, 14, address width; must cover SRC_BASE/DST_BASE + IMG_W*IMG_H-1
SRC_BASE, 0, source image base address
DST_BASE, 0, destination image base address (separate write memory)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a frame; sampled in IDLE only
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse in DONE state
rd_en  out  1  source memory read strobe
rd_addr  out  ADDR_W  source read address
rd_data  in  8  source data, valid the cycle after rd_en
tap_valid  out  1  rd_data is a window tap this cycle
tap_idx  out  4  tap index 0..8, row-major (dr=-1..1, dc=-1..1)
acc_clr  out  1  pulse: clear datapath accumulator (first fetch cycle of each interior pixel)
pix_valid  in  1  datapath result ready; held by datapath until next acc_clr
pix_result  in  8  datapath result (already >>4 scaled)
wr_en  out  1  destination write strobe
wr_addr  out  ADDR_W  destination write address
wr_data  out  8  destination write data

Behaviour:
- Reset (any cycle, including mid-frame): state=IDLE; row, col, tap counter = 0.
- Reset values: busy, done, rd_en, tap_valid, acc_clr, wr_en = 0; rd_addr, wr_addr, tap_idx, wr_data = 0. No further writes after reset.
- States: IDLE, BRD_RD, BRD_WR, FETCH, DRAIN, WAIT_RES, WRITE, DONE.
- IDLE:
  - start=1 -> row=col=0, go to BRD_RD (pixel (0,0) is border).
  - start while busy is ignored.
- Border pixel (row==0 | row==IMG_H-1 | col==0 | col==IMG_W-1):
  - BRD_RD: rd_en=1, rd_addr=SRC_BASE+row*IMG_W+col.
  - BRD_WR: wr_en=1, wr_addr=DST_BASE+row*IMG_W+col, wr_data=rd_data. Then advance.
- Interior pixel:
  - FETCH: 9 cycles, tap t=0..8; rd_en=1, rd_addr=SRC_BASE+(row+t/3-1)*IMG_W+(col+t%3-1); acc_clr=1 at t=0 only.
  - tap_valid/tap_idx are the rd_en/t pair delayed one cycle, aligned with rd_data.
  - DRAIN: 1 cycle; carries tap 8 valid.
  - WAIT_RES: stays until pix_valid=1; pix_valid is sampled only in this state. Latch pix_result.
  - WRITE: wr_en=1, wr_addr=DST_BASE+row*IMG_W+col, wr_data=latched result. Then advance.
- Advance:
  - col+1; at col==IMG_W-1 wrap col=0, row+1.
  - After pixel (IMG_H-1, IMG_W-1) go to DONE; otherwise to BRD_RD or FETCH per border test on the new (row, col).
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - No multipliers: row_base (=row*IMG_W) is maintained incrementally (+IMG_W on row wrap).
  - Tap addresses are row_base ± IMG_W ± 1, computed in ADDR_W bits; interior guarantees no underflow.
- Cycle budget:
  - Border pixel = 2 cycles.
  - Interior pixel = 12 cycles + extra WAIT_RES cycles.
  - Frame busy cycles = 2*B + 12*I + stalls + 1 (DONE).
- Only one of rd_en/wr_en-producing states is active per cycle; no read/write overlap.

Decomposition:
- Shared package conv_pkg: state enum, TAP_CNT=9, pixel/data width 8, border-test function.
- One natural sub-module, conv_addr_gen: row/col/row_base counters plus tap address computation. The FSM and handshake stay in conv_window_sched.

Test Plan:
- Reset: hold rst 3 cycles mid-FETCH -> all outputs 0, state IDLE, no wr_en afterwards; start next cycle begins at pixel (0,0).
- IMG_W=IMG_H=4, pix_valid tied 1 -> 12 border copies and 4 interior writes; busy high exactly 2*12+12*4+1=73 cycles; done single pulse.
- Pixel (1,1), IMG_W=4 -> rd_addr sequence 0,1,2,4,5,6,8,9,10; tap_idx 0..8 on the next cycles; acc_clr only with addr 0; write to DST_BASE+5.
- Border copy: source[3]=0xA5 -> wr_addr=DST_BASE+3, wr_data=0xA5 one cycle after read.
- Stall: pix_valid delayed 5 cycles for pixel (1,2) -> WAIT_RES held, no wr_en until the cycle after pix_valid; pix_result=0x3C written to addr 6.
- start pulsed while busy -> ignored; frame completes unchanged with exactly one done pulse.
